// File: rtl/hex_cmd_collector.sv
// hex_cmd_collector: gathers CHAR_NUM ASCII hex digits into a '0'-padded field with valid/ready and error reporting; HEX_LOWERCASE_EN accepts 'a'-'f'.
module hex_cmd_collector #(
    parameter int CHAR_NUM    = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            iRX_DATA,
    input  logic                  iRX_VALID,
    output logic [CHAR_NUM*8-1:0] oASCII,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oERR,
    output logic [1:0]            oERR_CODE,
    output logic                  oBUSY
);
    localparam int W  = CHAR_NUM * 8;
    localparam int CW = $clog2(CHAR_NUM + 1);
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CHAR_NUM);
    localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT_CYC);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [W-1:0]  ascii_q, ascii_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          busy_q, busy_d;
    logic          is_digit, is_upper, is_lower, is_hex, is_term;
    logic [7:0]    ch;
    logic [W-1:0]  base, shifted;

    always_comb begin
        is_digit = (iRX_DATA >= 8'h30) && (iRX_DATA <= 8'h39);
        is_upper = (iRX_DATA >= 8'h41) && (iRX_DATA <= 8'h46);
`ifdef HEX_LOWERCASE_EN
        is_lower = (iRX_DATA >= 8'h61) && (iRX_DATA <= 8'h66);
`else
        is_lower = 1'b0;
`endif
        is_hex   = is_digit || is_upper || is_lower;
        is_term  = (iRX_DATA == 8'h0D) || (iRX_DATA == 8'h0A);
        ch       = is_lower ? iRX_DATA - 8'h20 : iRX_DATA;
        // Starting from all-'0' makes left padding fall out of the shift.
        base     = (state_q == S_IDLE) ? {CHAR_NUM{8'h30}} : ascii_q;
        shifted  = W'({base, 8'h00}) | W'(ch);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        ascii_d    = ascii_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (iRX_VALID && is_hex) begin
                    ascii_d = shifted;
                    cnt_d   = CW'(1);
                    state_d = S_COLLECT;
                end else if (iRX_VALID && !is_term) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = S_DISCARD;
                end
            end
            S_COLLECT: begin
                if (iRX_VALID) begin
                    if (is_hex && cnt_q != CNT_FULL) begin
                        ascii_d = shifted;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (is_term) begin
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = is_hex ? 2'd2 : 2'd1;
                        state_d    = S_DISCARD;
                    end
                end else if (TIMEOUT_CYC != 0 && tmo_q == TMO_LIM) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = S_IDLE;
                end else begin
                    tmo_d = (TIMEOUT_CYC != 0) ? tmo_q + 1'b1 : '0;
                end
            end
            S_HOLD: begin
                if (iRX_VALID) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd0;
                end
                if (iREADY) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (iRX_VALID && is_term) state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            ascii_q    <= {CHAR_NUM{8'h30}};
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            ascii_q    <= ascii_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

    assign oASCII    = ascii_q;
    assign oVALID    = valid_q;
    assign oERR      = err_q;
    assign oERR_CODE = err_code_q;
    assign oBUSY     = busy_q;
endmodule

// File: tb/tb_hex_cmd_collector.sv
// tb_hex_cmd_collector: table vectors, corner sequences and random traffic against a queue-based reference model.
module tb_hex_cmd_collector;
    localparam int CN  = 2;
    localparam int TMO = 16;
    localparam int M_IDLE = 0, M_COLL = 1, M_HOLD = 2, M_DISC = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [7:0]    iRX_DATA = 8'h00;
    logic          iRX_VALID = 1'b0;
    logic          iREADY = 1'b0;
    logic [CN*8-1:0] oASCII;
    logic          oVALID, oERR, oBUSY;
    logic [1:0]    oERR_CODE;

    hex_cmd_collector #(.CHAR_NUM(CN), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RST(RST), .iRX_DATA(iRX_DATA), .iRX_VALID(iRX_VALID),
        .oASCII(oASCII), .oVALID(oVALID), .iREADY(iREADY),
        .oERR(oERR), .oERR_CODE(oERR_CODE), .oBUSY(oBUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: the collected digits live in a queue; the field is built from it on demand.
    int m_mode, cyc, last_cyc;
    logic [7:0] q[$];
    logic exp_valid, exp_err, exp_busy;
    logic [1:0] exp_code;
    logic [CN*8-1:0] exp_field;

    function automatic logic [CN*8-1:0] pack_q();
        logic [CN*8-1:0] f;
        for (int i = 0; i < CN; i++)
            f[i*8 +: 8] = (i < q.size()) ? q[q.size()-1-i] : 8'h30;
        return f;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_mode = M_IDLE;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        exp_code = 2'd0;
        exp_busy = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] d, input bit r);
        bit hex, term, lc;
        logic [7:0] up;
        cyc++;
        exp_err = 1'b0;
`ifdef HEX_LOWERCASE_EN
        lc = (d >= 8'h61 && d <= 8'h66);
`else
        lc = 1'b0;
`endif
        hex  = (d >= 8'h30 && d <= 8'h39) || (d >= 8'h41 && d <= 8'h46) || lc;
        term = (d == 8'h0D) || (d == 8'h0A);
        up   = lc ? d - 8'h20 : d;
        if (m_mode == M_IDLE) begin
            if (v && hex) begin
                q.delete(); q.push_back(up); m_mode = M_COLL; last_cyc = cyc;
            end else if (v && !term) begin
                exp_err = 1; exp_code = 1; m_mode = M_DISC;
            end
        end else if (m_mode == M_COLL) begin
            if (v) begin
                last_cyc = cyc;
                if (hex && q.size() == CN) begin exp_err = 1; exp_code = 2; m_mode = M_DISC; end
                else if (hex) q.push_back(up);
                else if (term) begin m_mode = M_HOLD; exp_valid = 1; exp_field = pack_q(); end
                else begin exp_err = 1; exp_code = 1; m_mode = M_DISC; end
            end else if (TMO != 0 && cyc - last_cyc == TMO + 1) begin
                exp_err = 1; exp_code = 3; m_mode = M_IDLE;
            end
        end else if (m_mode == M_HOLD) begin
            if (v) begin exp_err = 1; exp_code = 0; end
            if (r) begin exp_valid = 0; m_mode = M_IDLE; end
        end else if (v && term) m_mode = M_IDLE;
        exp_busy = (m_mode != M_IDLE);
    endfunction

    logic err_seen, valid_seen;
    logic [1:0] code_seen;
    logic [CN*8-1:0] field_seen;

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        iRX_VALID = v;
        iRX_DATA = d;
        iREADY = r;
        if (RST) model_reset(); else model_step(v, d, r);
        @(posedge CLK);
        @(negedge CLK);
        chk("m_valid", 32'(oVALID), 32'(exp_valid));
        chk("m_err", 32'(oERR), 32'(exp_err));
        chk("m_busy", 32'(oBUSY), 32'(exp_busy));
        if (exp_err) chk("m_code", 32'(oERR_CODE), 32'(exp_code));
        if (exp_valid) chk("m_field", 32'(oASCII), 32'(exp_field));
        if (oERR) begin err_seen = 1; code_seen = oERR_CODE; end
        if (oVALID) begin valid_seen = 1; field_seen = oASCII; end
    endtask

    task automatic clr_seen();
        err_seen = 0; valid_seen = 0; code_seen = 0; field_seen = 0;
    endtask

    typedef struct {
        logic [31:0] b;
        int          n;
        bit          ev;
        logic [15:0] ef;
        bit          ee;
        logic [1:0]  ec;
    } vec_t;
    vec_t tv[12];

    task automatic run_vec(input vec_t t);
        clr_seen();
        for (int k = 0; k < t.n; k++) step(1, t.b[(t.n-1-k)*8 +: 8], 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("row_err", 32'(err_seen), 32'(t.ee));
        if (t.ee) chk("row_code", 32'(code_seen), 32'(t.ec));
        chk("row_valid", 32'(valid_seen), 32'(t.ev));
        if (t.ev) chk("row_field", 32'(field_seen), 32'(t.ef));
        if (valid_seen) begin
            step(0, 8'h00, 1);
            chk("row_ack", 32'(oVALID), 32'd0);
        end
    endtask

    initial begin
        int lat, g, k, hv;
        logic [7:0] by;
        tv[0]  = '{32'h0033_460D, 3, 1, 16'h3346, 0, 0};
        tv[1]  = '{32'h0D0A_370A, 4, 1, 16'h3037, 0, 0};
        tv[2]  = '{32'h0000_000A, 1, 0, 16'h0000, 0, 0};
        tv[3]  = '{32'h0031_470D, 3, 0, 16'h0000, 1, 1};
        tv[4]  = '{32'h0041_420D, 3, 1, 16'h4142, 0, 0};
        tv[5]  = '{32'h3132_330D, 4, 0, 16'h0000, 1, 2};
`ifdef HEX_LOWERCASE_EN
        tv[6]  = '{32'h0061_620D, 3, 1, 16'h4142, 0, 0};
`else
        tv[6]  = '{32'h0061_620D, 3, 0, 16'h0000, 1, 1};
`endif
        tv[7]  = '{32'h0000_300D, 2, 1, 16'h3030, 0, 0};
        tv[8]  = '{32'h0045_390A, 3, 1, 16'h4539, 0, 0};
        tv[9]  = '{32'h0000_5A0D, 2, 0, 16'h0000, 1, 1};
        tv[10] = '{32'h0041_2A0D, 3, 0, 16'h0000, 1, 1};
        tv[11] = '{32'h0000_390D, 2, 1, 16'h3039, 0, 0};
        cyc = 0;
        last_cyc = 0;
        clr_seen();
        @(negedge CLK);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0);
        chk("rst_ascii", 32'(oASCII), 32'h3030);
        chk("rst_valid", 32'(oVALID), 32'd0);
        chk("rst_err", 32'(oERR), 32'd0);
        chk("rst_code", 32'(oERR_CODE), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(tv[i]);

        // HOLD: field stable while stalled, stray byte rejected without disturbing it
        step(1, 8'h33, 0); step(1, 8'h46, 0); step(1, 8'h0D, 0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(oVALID), 32'd1);
            chk("hold_ascii", 32'(oASCII), 32'h3346);
            step(0, 8'h00, 0);
        end
        step(1, 8'h58, 0);
        chk("hold_drop_err", 32'(oERR), 32'd1);
        chk("hold_drop_code", 32'(oERR_CODE), 32'd0);
        chk("hold_drop_ascii", 32'(oASCII), 32'h3346);
        step(0, 8'h00, 1);
        chk("ack_valid", 32'(oVALID), 32'd0);

        // Byte on the handshake cycle is dropped; the very next byte starts a field
        step(1, 8'h31, 0); step(1, 8'h32, 0); step(1, 8'h0A, 0);
        step(1, 8'h35, 1);
        chk("hs_drop_err", 32'(oERR), 32'd1);
        chk("hs_drop_code", 32'(oERR_CODE), 32'd0);
        chk("hs_valid", 32'(oVALID), 32'd0);
        step(1, 8'h39, 0);
        chk("hs_next_busy", 32'(oBUSY), 32'd1);
        step(1, 8'h0D, 0);
        chk("hs_next_field", 32'(oASCII), 32'h3039);
        step(0, 8'h00, 1);

        // Inter-character timeout
        step(1, 8'h35, 0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 8'h00, 0);
            if (oERR) begin lat = i; break; end
        end
        chk("tmo_latency", 32'(lat), 32'd17);
        chk("tmo_code", 32'(oERR_CODE), 32'd3);
        chk("tmo_busy", 32'(oBUSY), 32'd0);
        clr_seen();
        step(1, 8'h39, 0); step(1, 8'h0D, 0);
        chk("tmo_next_field", 32'(oASCII), 32'h3039);
        step(0, 8'h00, 1);

        // Reset mid-field and mid-HOLD lose the data silently
        clr_seen();
        step(1, 8'h37, 0);
        RST = 1'b1; step(0, 8'h00, 0); RST = 1'b0;
        step(1, 8'h34, 0); step(1, 8'h0D, 0);
        RST = 1'b1; step(0, 8'h00, 1); RST = 1'b0;
        step(0, 8'h00, 0);
        chk("rst_mid_valid", 32'(oVALID), 32'd0);
        chk("rst_mid_err", 32'(oERR), 32'd0);
        chk("rst_mid_busy", 32'(oBUSY), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            g = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 2);
            for (int i = 0; i < g; i++) step(0, 8'h00, $urandom_range(0, 2) == 0);
            k = $urandom_range(0, 9);
            hv = $urandom_range(0, 15);
            by = (hv < 10) ? 8'(8'h30 + hv) : 8'(8'h41 + hv - 10);
            if (k == 5) by = 8'h0D;
            else if (k == 6) by = 8'h0A;
            else if (k == 7) by = 8'(8'h61 + $urandom_range(0, 5));
            else if (k == 8) by = 8'($urandom_range(0, 255));
            step(1, by, $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
